ebus_xfer_seq: RTL and testbench

EBOX-side EBUS transaction sequencer for DATAI/DATAO/CONI/CONO-class I/O. It sits downstream of the EDP: it takes the 36-bit word the EDP puts out on its AD→EBUS path, runs the EBUS select/demand/transfer handshake with a device, and returns either the read word (for loading into AR) or a timeout indication to CTL. It owns only the protocol timing; it does not decide which instruction is executing.

---
 rtl/ebus_xfer_seq_pkg.sv | 27 ++
 rtl/ebus_cycle_ctr.sv | 30 +++
 rtl/ebus_xfer_seq.sv | 177 +++++++++++++++++
 tb/tb_ebus_xfer_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ebus_xfer_seq_pkg.sv
// Shared types and constants for the EBOX-side EBUS transaction sequencer.
package ebus_xfer_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_DEMAND  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } tEBUSxferState;

  // EBUS function codes as driven on the FCN lines.
  localparam logic [2:0] FCN_CONO  = 3'd0;
  localparam logic [2:0] FCN_CONI  = 3'd1;
  localparam logic [2:0] FCN_DATAO = 3'd2;
  localparam logic [2:0] FCN_DATAI = 3'd3;

  // Width of the shared phase counter; covers the largest timeout (255).
  localparam int CTR_W = 8;

  // True in the states where CS/FCN (and write data) are put on the bus.
  function automatic logic bus_active(input tEBUSxferState st);
    return (st == ST_SETUP) || (st == ST_DEMAND) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/ebus_cycle_ctr.sv
// Loadable down-counter with terminal-count flag, used to time the SETUP,
// DEMAND-timeout and RELEASE phases of an EBUS transfer.
module ebus_cycle_ctr
  import ebus_xfer_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             CROBAR_N,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic             tc
);

  logic [CTR_W-1:0] cnt_r;

  // Load a phase length, otherwise count down and park at zero.
  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      cnt_r <= {CTR_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CTR_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CTR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CTR_W{1'b0}});

endmodule

// File: rtl/ebus_xfer_seq.sv
// EBOX-side EBUS transaction sequencer: runs select/demand/transfer with a
// device and returns the read word or a timeout indication.
module ebus_xfer_seq
  import ebus_xfer_seq_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int RELEASE_CYC = 1
) (
  input  logic        CLK,
  input  logic        CROBAR_N,
  input  logic        start,
  input  logic        wr,
  input  logic [6:0]  dev,
  input  logic [2:0]  fcn,
  input  logic [35:0] wdata,
  input  logic        ebus_xfer,
  input  logic [35:0] ebus_din,
  output logic [6:0]  ebus_cs,
  output logic [2:0]  ebus_fcn,
  output logic        ebus_demand,
  output logic        ebus_drive,
  output logic [35:0] ebus_dout,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [35:0] rdata
);

  localparam logic [CTR_W-1:0] SETUP_LD   = CTR_W'(SETUP_CYC - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LD = CTR_W'(TIMEOUT_CYC - 1);
  localparam logic [CTR_W-1:0] RELEASE_LD = CTR_W'(RELEASE_CYC - 1);

  tEBUSxferState    state_r, state_nx_s;
  logic             wr_r;
  logic [6:0]       dev_r;
  logic [2:0]       fcn_r;
  logic [35:0]      wdata_r;
  logic             ctr_load_s;
  logic [CTR_W-1:0] ctr_val_s;
  logic             ctr_tc_s;
  logic             capture_s;
  logic             to_hit_s;
  logic             finish_s;
  logic             done_r;
  logic             timeout_r;
  logic [35:0]      rdata_r;
  logic             bus_on_s;

  ebus_cycle_ctr u_ctr (
    .CLK      (CLK),
    .CROBAR_N (CROBAR_N),
    .load     (ctr_load_s),
    .load_val (ctr_val_s),
    .tc       (ctr_tc_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, phase-counter loads and completion/capture strobes.
  always_comb begin
    state_nx_s = state_r;
    ctr_load_s = 1'b0;
    ctr_val_s  = {CTR_W{1'b0}};
    capture_s  = 1'b0;
    to_hit_s   = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_SETUP;
          ctr_load_s = 1'b1;
          ctr_val_s  = SETUP_LD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (ctr_tc_s) begin
          state_nx_s = ST_DEMAND;
          ctr_load_s = 1'b1;
          ctr_val_s  = TIMEOUT_LD;
        end else begin
          state_nx_s = ST_SETUP;
        end
      end
      ST_DEMAND: begin
        if (ebus_xfer) begin
          state_nx_s = ST_HOLD;
          capture_s  = ~wr_r;
        end else if (ctr_tc_s) begin
          state_nx_s = ST_RELEASE;
          to_hit_s   = 1'b1;
          finish_s   = 1'b1;
          ctr_load_s = 1'b1;
          ctr_val_s  = RELEASE_LD;
        end else begin
          state_nx_s = ST_DEMAND;
        end
      end
      ST_HOLD: begin
        // No timeout here: a device that never drops XFER holds the bus.
        if (!ebus_xfer) begin
          state_nx_s = ST_RELEASE;
          finish_s   = 1'b1;
          ctr_load_s = 1'b1;
          ctr_val_s  = RELEASE_LD;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        if (ctr_tc_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RELEASE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Request latch: captured only when a start is accepted in IDLE.
  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      wr_r    <= 1'b0;
      dev_r   <= 7'd0;
      fcn_r   <= 3'd0;
      wdata_r <= 36'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      wr_r    <= wr;
      dev_r   <= dev;
      fcn_r   <= fcn;
      wdata_r <= wr ? wdata : 36'd0;
    end else begin
      wr_r    <= wr_r;
      dev_r   <= dev_r;
      fcn_r   <= fcn_r;
      wdata_r <= wdata_r;
    end
  end

  // Completion pulse, timeout flag and read-data capture.
  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      rdata_r   <= 36'd0;
    end else begin
      done_r    <= finish_s;
      timeout_r <= finish_s & to_hit_s;
      rdata_r   <= capture_s ? ebus_din : rdata_r;
    end
  end

  // Bus outputs decode straight from flops, so reset clears them at once.
  assign bus_on_s    = bus_active(state_r);
  assign ebus_cs     = bus_on_s ? dev_r : 7'd0;
  assign ebus_fcn    = bus_on_s ? fcn_r : 3'd0;
  assign ebus_drive  = bus_on_s & wr_r;
  assign ebus_dout   = (bus_on_s && wr_r) ? wdata_r : 36'd0;
  assign ebus_demand = (state_r == ST_DEMAND);
  assign busy        = (state_r != ST_IDLE);
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign rdata       = rdata_r;

endmodule

// File: tb/tb_ebus_xfer_seq.sv
// Scoreboard bench for ebus_xfer_seq: stimulus pushes expected completions,
// a monitor pops and compares them whenever done is presented.
module tb_ebus_xfer_seq;
  import ebus_xfer_seq_pkg::*;

  localparam int TO_CYC = 64;

  logic        CLK = 1'b0;
  logic        CROBAR_N = 1'b0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [6:0]  dev = 7'd0;
  logic [2:0]  fcn = 3'd0;
  logic [35:0] wdata = 36'd0;
  logic        ebus_xfer = 1'b0;
  logic [35:0] ebus_din = 36'd0;
  logic [6:0]  ebus_cs;
  logic [2:0]  ebus_fcn;
  logic        ebus_demand;
  logic        ebus_drive;
  logic [35:0] ebus_dout;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [35:0] rdata;

  typedef struct {
    logic        to;
    logic [35:0] rd;
    int          at;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [35:0] model_rdata = 36'd0;

  ebus_xfer_seq dut (
    .CLK         (CLK),
    .CROBAR_N    (CROBAR_N),
    .start       (start),
    .wr          (wr),
    .dev         (dev),
    .fcn         (fcn),
    .wdata       (wdata),
    .ebus_xfer   (ebus_xfer),
    .ebus_din    (ebus_din),
    .ebus_cs     (ebus_cs),
    .ebus_fcn    (ebus_fcn),
    .ebus_demand (ebus_demand),
    .ebus_drive  (ebus_drive),
    .ebus_dout   (ebus_dout),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .rdata       (rdata)
  );

  always #5 CLK = ~CLK;

  // Edge counter used to time completions.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done === 1'b1) begin
        check("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("done_timeout", 128'(timeout), 128'(e.to));
          check("done_rdata", 128'(rdata), 128'(e.rd));
          check("done_cycle", 128'(cyc), 128'(e.at));
        end
      end
    end
  end

  // One transaction: k = DEMAND cycle in which XFER rises (0 = never),
  // h = cycles XFER stays high, spur = extra start pulse during DEMAND.
  task automatic xact(input string tag, input logic w, input logic [6:0] d,
                      input logic [2:0] f, input logic [35:0] wd,
                      input logic [35:0] din, input int k, input int h,
                      input bit spur);
    int   s, done_rel, bus_end, dem_cnt;
    bit   bus_bad, rel_bad;
    exp_t e;
    @(negedge CLK);
    check({tag, "_idle_pre"}, 128'({busy, ebus_cs, ebus_fcn, ebus_demand, ebus_drive, ebus_dout}), 128'd0);
    s = cyc;
    start = 1'b1; wr = w; dev = d; fcn = f; wdata = wd; ebus_din = din;
    done_rel = (k > 0) ? (3 + k + h) : (3 + TO_CYC);
    bus_end  = done_rel - 1;
    if ((k > 0) && !w) model_rdata = din;
    e.to = (k == 0);
    e.rd = model_rdata;
    e.at = s + done_rel;
    sb_q.push_back(e);
    dem_cnt = 0; bus_bad = 1'b0; rel_bad = 1'b0;
    for (int rel = 1; rel <= done_rel; rel++) begin
      @(negedge CLK);
      if (ebus_demand === 1'b1) dem_cnt++;
      if (rel <= bus_end) begin
        if (ebus_cs !== d || ebus_fcn !== f || ebus_drive !== w ||
            ebus_dout !== (w ? wd : 36'd0) || busy !== 1'b1) bus_bad = 1'b1;
      end else begin
        if ({ebus_cs, ebus_fcn, ebus_demand, ebus_drive, ebus_dout} !== 48'd0) rel_bad = 1'b1;
      end
      start = spur && (rel == 4);
      dev   = (spur && (rel == 4)) ? 7'o077 : d;
      if ((k > 0) && (rel == 2 + k)) ebus_xfer = 1'b1;
      if ((k > 0) && (rel == 2 + k + h)) ebus_xfer = 1'b0;
    end
    check({tag, "_demand_cycles"}, 128'(dem_cnt), 128'((k > 0) ? k : TO_CYC));
    check({tag, "_bus_stable"}, 128'(bus_bad), 128'd0);
    check({tag, "_bus_released"}, 128'(rel_bad), 128'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge CLK);
    check("reset_outputs", {ebus_cs, ebus_fcn, ebus_demand, ebus_drive, ebus_dout,
                            busy, done, timeout, rdata}, 128'd0);
    CROBAR_N = 1'b1;

    // Minimum read, write with XFER on DEMAND cycle 3, timeout.
    xact("rd", 1'b0, 7'o004, 3'b001, 36'd0, 36'o123456_654321, 1, 1, 1'b0);
    xact("wr", 1'b1, 7'o020, FCN_DATAO, 36'o777000_000777, 36'o555555_555555, 3, 1, 1'b0);
    xact("to", 1'b0, 7'o030, FCN_DATAI, 36'd0, 36'o7, 0, 0, 1'b0);

    // Start while busy is ignored; back-to-back start right after done.
    xact("spur", 1'b0, 7'o040, FCN_DATAI, 36'd0, 36'o000111_222333, 3, 1, 1'b1);
    xact("b2b", 1'b0, 7'o041, FCN_CONI, 36'd0, 36'o000000_000444, 1, 1, 1'b0);

    // Reset while in HOLD with XFER high.
    @(negedge CLK);
    start = 1'b1; wr = 1'b0; dev = 7'o010; fcn = FCN_DATAI; ebus_din = 36'o111111_222222;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK); ebus_xfer = 1'b1;
    @(negedge CLK);
    check("hold_before_reset", 128'({busy, ebus_demand}), 128'(2'b10));
    check("hold_rdata", 128'(rdata), 128'(36'o111111_222222));
    #2 CROBAR_N = 1'b0;
    #1;
    check("async_reset_outputs", {ebus_cs, ebus_fcn, ebus_demand, ebus_drive, ebus_dout,
                                  busy, done, timeout, rdata}, 128'd0);
    model_rdata = 36'd0;
    @(negedge CLK);
    CROBAR_N = 1'b1;
    ebus_xfer = 1'b0;
    xact("post_rst", 1'b0, 7'o004, FCN_DATAI, 36'd0, 36'o246135_753102, 1, 1, 1'b0);

    // Slow XFER drop: held for 10 cycles.
    xact("slow", 1'b0, 7'o050, FCN_DATAI, 36'd0, 36'o000000_000001, 1, 10, 1'b0);

    repeat (10) @(negedge CLK);
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
